// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Single-outstanding Wishbone classic master. Takes register read/write
//   requests over a valid/ready interface, runs one Wishbone cycle per
//   request and returns read data or a timeout error over a valid/ready
//   response interface.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready high only in IDLE)
//   req_we/adr/dat/sel    request payload
//   rsp_valid/rsp_ready   response handshake (response held until taken)
//   rsp_rdata, rsp_err    read data (0 for writes/errors), timeout flag
//   wb_*_o, wb_dat_i,
//   wb_ack_i              Wishbone classic master port (outputs registered)
//   busy                  high whenever the FSM is not IDLE
//   txn_count             completed transactions (ok or error), wraps
module wb_cmd_master #(
  parameter int ADR_W          = 32,
  parameter int DAT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADR_W-1:0]   req_adr,
  input  logic [DAT_W-1:0]   req_dat,
  input  logic [DAT_W/8-1:0] req_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic [ADR_W-1:0]   wb_adr_o,
  output logic [DAT_W-1:0]   wb_dat_o,
  output logic [DAT_W/8-1:0] wb_sel_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  input  logic [DAT_W-1:0]   wb_dat_i,
  input  logic               wb_ack_i,
  output logic               busy,
  output logic [CNT_W-1:0]   txn_count
);

  localparam int SEL_W = DAT_W / 8;
  // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_reg;
  logic [ADR_W-1:0]   adr_reg;
  logic [DAT_W-1:0]   dat_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               we_reg;
  logic               cyc_reg;
  logic [TO_W-1:0]    tmo_reg;
  logic               rsp_valid_reg;
  logic               rsp_err_reg;
  logic [DAT_W-1:0]   rsp_rdata_reg;
  logic [CNT_W-1:0]   txn_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      adr_reg       <= '0;
      dat_reg       <= '0;
      sel_reg       <= '0;
      we_reg        <= 1'b0;
      cyc_reg       <= 1'b0;
      tmo_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      txn_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            adr_reg   <= req_adr;
            // Reads never put stale request data on the bus.
            dat_reg   <= req_we ? req_dat : '0;
            sel_reg   <= req_sel;
            we_reg    <= req_we;
            cyc_reg   <= 1'b1;
            tmo_reg   <= '0;
            state_reg <= BUS;
          end
        end
        BUS: begin
          // Ack is tested first so it wins over a same-cycle timeout.
          if (wb_ack_i) begin
            cyc_reg       <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= we_reg ? '0 : wb_dat_i;
            txn_count_reg <= txn_count_reg + CNT_W'(1);
            state_reg     <= RESP;
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_reg == TO_LAST)) begin
            cyc_reg       <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b1;
            rsp_rdata_reg <= '0;
            txn_count_reg <= txn_count_reg + CNT_W'(1);
            state_reg     <= RESP;
          end else begin
            // With the timeout disabled this simply free-runs.
            tmo_reg <= tmo_reg + TO_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

  // cyc and stb come from one register so they can never disagree.
  assign wb_cyc_o  = cyc_reg;
  assign wb_stb_o  = cyc_reg;
  assign wb_adr_o  = adr_reg;
  assign wb_dat_o  = dat_reg;
  assign wb_sel_o  = sel_reg;
  assign wb_we_o   = we_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign txn_count = txn_count_reg;

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Single-outstanding Wishbone classic master. Sits directly upstream of the Wishbone-slave timer/counter block and drives its wb_* slave port.
- Accepts register write/read requests from local control logic (button FSM, UART command decoder) over a valid/ready interface.
- Runs one classic Wishbone cycle per request and returns read data or a timeout error over a valid/ready response interface.

Parameters:
- ADR_W, 32, address width of the request and the wb_adr_o bus.
- DAT_W, 32, data width; sel width is DAT_W/8.
- TIMEOUT_CYCLES, 255, max cycles stb may wait for ack before abort; 0 disables the timeout (wait forever).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request
- req_we  in  1  1 = write, 0 = read
- req_adr  in  ADR_W  target address
- req_dat  in  DAT_W  write data
- req_sel  in  DAT_W/8  byte enables
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  DAT_W  read data; 0 for writes and errors
- rsp_err  out  1  1 = timeout abort
- wb_adr_o  out  ADR_W  Wishbone address
- wb_dat_o  out  DAT_W  Wishbone write data
- wb_sel_o  out  DAT_W/8  Wishbone byte select
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_dat_i  in  DAT_W  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- busy  out  1  high in any state other than IDLE
- txn_count  out  CNT_W  count of completed transactions, ok or error

Behaviour:
- Reset values:
  - State is IDLE. req_ready=1 (it is combinational, high only in IDLE).
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0; wb_adr_o, wb_dat_o, wb_sel_o = 0.
  - busy=0, txn_count=0, timeout counter=0.
  - A reset mid-cycle drops cyc/stb on the next edge. No response is produced for the aborted request.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at edge N: register adr, dat, sel and we into the wb_* outputs. Force wb_dat_o=0 when it is a read.
  - Set wb_cyc_o = wb_stb_o = 1, clear the timeout counter and go to BUS. cyc/stb are visible in cycle N+1.
- BUS:
  - cyc, stb, adr, dat, sel and we are held stable. Timeout counter increments each cycle.
  - wb_ack_i sampled high:
    - On that edge: drop cyc/stb and set rsp_valid=1, rsp_err=0.
    - rsp_rdata = wb_dat_i for a read, 0 for a write.
    - Increment txn_count and go to RESP.
    - A combinational slave ack gives req-accept-to-rsp_valid latency of 2 cycles.
  - TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with no ack:
    - Drop cyc/stb; set rsp_valid=1, rsp_err=1, rsp_rdata=0.
    - Increment txn_count and go to RESP.
  - Ack and timeout on the same cycle: ack wins, rsp_err=0.
- RESP:
  - rsp_valid, rsp_err and rsp_rdata are held while rsp_ready=0.
  - On rsp_ready: clear rsp_valid and go to IDLE. The next request can be accepted one cycle later. There is no back-to-back overlap and only one transaction is ever in flight.
- Wishbone outputs are fully registered. cyc and stb are always equal.
- wb_ack_i outside BUS is ignored: no state change and no counter change.
- txn_count wraps from 2^CNT_W-1 to 0.
- busy = (state != IDLE).

Test Plan:
- Write: req adr=0x4, dat=0x0000_0001, sel=0xF, we=1; slave acks 1 cycle after stb -> cyc/stb high exactly 2 cycles with stable adr/dat; rsp_valid, rsp_err=0, rsp_rdata=0; txn_count=1.
- Read: req adr=0x8, we=0; slave returns wb_dat_i=0x0000_0007 with combinational ack -> rsp_valid 2 cycles after accept, rsp_rdata=0x7; wb_dat_o=0 throughout.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> stb high exactly 4 cycles; then rsp_err=1, rsp_rdata=0, cyc=0; txn_count increments.
- Backpressure: rsp_ready held 0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable; req_ready=0 and new req_valid not accepted until one cycle after rsp_ready=1.
- Reset mid-BUS: assert rst while stb=1 -> next edge cyc=stb=0, rsp_valid=0, txn_count=0, req_ready=1; a stray ack the cycle after is ignored.
- Wrap: CNT_W=2, 5 transactions -> txn_count 1,2,3,0,1.
